// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle RV32I control FSM.
// Sequences FETCH/DECODE/EXECUTE/WB over a shared memory port with a ready
// handshake and a bounded wait-state timeout; drives datapath muxes/enables.
// Optional feature: define BRANCH_EN to accept beq/bne (opcode 1100011).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   instruction         IR contents (valid from DECODE on)
//   zero                ALU zero flag (used in BRANCH)
//   mem_ready           memory completes the current access this cycle
//   mem_req, adr_src    memory request / address source (0 PC, 1 ALU-out)
//   ir_we, pc_we        IR / PC load enables
//   dmem_we, rf_we      memory write / register file write
//   sel_ext             000 I, 001 S, 010 B, 011 U, 100 J
//   sel_alu_src_a/b     ALU operand selects
//   sel_result          00 ALU-out, 01 mem data, 10 ALU result, 11 immediate
//   alu_control         {funct3,funct7[5]} style ALU code, 0000 ADD
//   state_o             current state (debug): 0 FETCH,1 DECODE,2 MEM_ADR,
//                       3 MEM_RD,4 MEM_WB,5 MEM_WR,6 EXEC_R,7 EXEC_I,
//                       8 ALU_WB,9 JAL,10 LUI,11 BRANCH,12 HALT
//   fault               sticky: 00 none, 01 illegal opcode, 10 memory timeout
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        adr_src,
  output logic        ir_we,
  output logic        pc_we,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [2:0]  sel_ext,
  output logic [1:0]  sel_alu_src_a,
  output logic [1:0]  sel_alu_src_b,
  output logic [1:0]  sel_result,
  output logic [3:0]  alu_control,
  output logic [3:0]  state_o,
  output logic [1:0]  fault
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
`ifdef BRANCH_EN
  localparam logic [6:0] OP_BR    = 7'b1100011;
`endif

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALU_WB  = 4'd8,
    S_JAL     = 4'd9,
    S_LUI     = 4'd10,
`ifdef BRANCH_EN
    S_BRANCH  = 4'd11,
`endif
    S_HALT    = 4'd12
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [1:0]       fault_q, fault_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_instr_bits;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7_5 = instruction[30];
  assign unused_instr_bits = ^{instruction[31], instruction[29:15],
                               instruction[11:7], zero};

  // State, wait counter and sticky fault registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      fault_q <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Next-state and datapath controls
  always_comb begin
    state_d       = state_q;
    fault_d       = fault_q;
    wait_d        = '0;
    mem_req       = 1'b0;
    adr_src       = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    dmem_we       = 1'b0;
    rf_we         = 1'b0;
    sel_ext       = 3'b000;
    sel_alu_src_a = 2'b00;
    sel_alu_src_b = 2'b00;
    sel_result    = 2'b00;
    alu_control   = 4'b0000;
    state_o       = state_q;
    fault         = fault_q;

    case (state_q)
      S_FETCH: begin
        mem_req       = 1'b1;
        sel_alu_src_b = 2'b10;
        sel_result    = 2'b10;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU-out captures PC+imm for a later jump/branch target
        sel_alu_src_a = 2'b01;
        sel_alu_src_b = 2'b01;
        sel_ext       = (opcode == OP_JAL) ? 3'b100 : 3'b010;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
`ifdef BRANCH_EN
          OP_BR:             state_d = S_BRANCH;
`endif
          default: begin
            state_d = S_HALT;
            fault_d = 2'b01;
          end
        endcase
      end
      S_MEM_ADR: begin
        sel_alu_src_a = 2'b10;
        sel_alu_src_b = 2'b01;
        sel_ext       = (opcode == OP_STORE) ? 3'b001 : 3'b000;
        state_d       = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        rf_we      = 1'b1;
        sel_result = 2'b01;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        dmem_we = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        sel_alu_src_a = 2'b10;
        alu_control   = {funct3, funct7_5};
        state_d       = S_ALU_WB;
      end
      S_EXEC_I: begin
        // funct7[5] only distinguishes srai from srli
        sel_alu_src_a = 2'b10;
        sel_alu_src_b = 2'b01;
        alu_control   = {funct3, (funct3 == 3'b101) ? funct7_5 : 1'b0};
        state_d       = S_ALU_WB;
      end
      S_ALU_WB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target held in ALU-out while the ALU forms old PC+4
        sel_alu_src_a = 2'b01;
        sel_alu_src_b = 2'b10;
        pc_we         = 1'b1;
        state_d       = S_ALU_WB;
      end
      S_LUI: begin
        rf_we      = 1'b1;
        sel_ext    = 3'b011;
        sel_result = 2'b11;
        state_d    = S_FETCH;
      end
`ifdef BRANCH_EN
      S_BRANCH: begin
        sel_alu_src_a = 2'b10;
        alu_control   = 4'b0001;
        state_d       = S_FETCH;
        case (funct3)
          3'b000:  pc_we = zero;
          3'b001:  pc_we = ~zero;
          default: begin
            state_d = S_HALT;
            fault_d = 2'b01;
          end
        endcase
      end
`endif
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Wait-state timeout; a completion on the last allowed cycle wins
    if (mem_req && !mem_ready) begin
      if (wait_q == CNT_W'(MEM_TIMEOUT - 1)) begin
        state_d = S_HALT;
        fault_d = 2'b10;
      end else begin
        wait_d = wait_q + CNT_W'(1);
      end
    end

    // Reset forces the port quiet immediately, not at the next edge
    if (rst) begin
      mem_req       = 1'b0;
      adr_src       = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      dmem_we       = 1'b0;
      rf_we         = 1'b0;
      sel_ext       = 3'b000;
      sel_alu_src_a = 2'b00;
      sel_alu_src_b = 2'b00;
      sel_result    = 2'b00;
      alu_control   = 4'b0000;
    end
  end

endmodule
